// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM encoding,
// and the byte-lane helpers used on the store and load paths.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3[1:0])
            2'b00:   byte_mask = 4'b0001 << lane;
            2'b01:   byte_mask = 4'b0011 << lane;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    // Pick the addressed byte/half out of the RAM word, then sign- or zero-extend.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] funct3,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    load_extend = {{24{b[7]}}, b};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_BU:   load_extend = {24'd0, b};
            F3_HU:   load_extend = {16'd0, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM bank with per-byte write enables, read-first,
// shaped so synthesis maps it onto block RAM.
module dmem_bank #(
    parameter int    DEPTH_WORDS = 16384,
    parameter string INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset; a reset term would stop block-RAM inference,
    // and stored data must survive rst anyway.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: valid/ready request port, RISC-V sub-word
// loads/stores, alignment/range/funct3 checking and a 1- or 2-cycle load response.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 16384,
    parameter int    READ_LAT    = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state, next_state;
    logic [1:0]  lane;
    logic        size_ok, f3_ok, in_range, req_err, accept;
    logic [3:0]  bank_we;
    logic [31:0] bank_wdata, bank_rdata, pipe_q, load_word, rsp_data_now, rdata_hold;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic        load_q, err_q, err_hold;

    assign lane     = req_addr[1:0];
    assign in_range = (req_addr >> (AW + 2)) == 32'd0;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        size_ok    = 1'b0;
        f3_ok      = 1'b0;
        bank_wdata = req_wdata;
        case (req_funct3)
            F3_B, F3_BU: size_ok = 1'b1;
            F3_H, F3_HU: size_ok = !lane[0];
            F3_W:        size_ok = (lane == 2'd0);
            default:     size_ok = 1'b0;
        endcase
        if (req_we) f3_ok = req_funct3 inside {F3_B, F3_H, F3_W};
        else        f3_ok = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        case (req_funct3[1:0])
            2'b00:   bank_wdata = {4{req_wdata[7:0]}};
            2'b01:   bank_wdata = {2{req_wdata[15:0]}};
            default: bank_wdata = req_wdata;
        endcase
    end

    assign req_err = !(size_ok && f3_ok && in_range);
    assign accept  = req_valid && req_ready;
    assign bank_we = (accept && req_we && !req_err) ? byte_mask(req_funct3, lane) : 4'b0000;

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_FILE  (INIT_FILE)
    ) u_bank (
        .clk  (clk),
        .en   (accept && !req_err),
        .we   (bank_we),
        .addr (req_addr[AW+1:2]),
        .wdata(bank_wdata),
        .rdata(bank_rdata)
    );

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (accept)
                    next_state = (READ_LAT == 2 && !req_we && !req_err) ? WAIT : RESP;
            end
            WAIT:    next_state = RESP;
            RESP: begin
                rsp_valid  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q   <= 3'd0;
            lane_q     <= 2'd0;
            load_q     <= 1'b0;
            err_q      <= 1'b0;
            pipe_q     <= 32'd0;
            rdata_hold <= 32'd0;
            err_hold   <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q <= req_funct3;
                lane_q   <= lane;
                load_q   <= !req_we && !req_err;
                err_q    <= req_err;
            end
            if (state == WAIT) pipe_q <= bank_rdata;
            if (rsp_valid) begin
                rdata_hold <= rsp_data_now;
                err_hold   <= err_q;
            end
        end
    end

    // Outputs show the live result during RESP and the last result otherwise.
    assign load_word    = (READ_LAT == 2) ? pipe_q : bank_rdata;
    assign rsp_data_now = load_q ? load_extend(load_word, funct3_q, lane_q) : 32'd0;
    assign rsp_rdata    = rsp_valid ? rsp_data_now : rdata_hold;
    assign rsp_err      = rsp_valid ? err_q : err_hold;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench: drives identical directed traffic into a READ_LAT=1 and a
// READ_LAT=2 controller and compares both against a byte-array memory model.
module tb_dmem_ctrl;

    localparam int DEPTH = 16384;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        valid [2];
    logic        we    [2];
    logic [2:0]  f3    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        rdy   [2];
    logic        rv    [2];
    logic [31:0] rdata [2];
    logic        rerr  [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: byte-addressed memory and the single outstanding response.
    logic [7:0]  mm [2][DEPTH*4];
    bit          pend [2];
    int          due  [2];
    int          busy [2];
    logic [31:0] exp_rdata [2];
    logic        exp_err   [2];

    logic [31:0] got_rdata [2];
    logic        got_err   [2];
    int          got_lat   [2];
    logic [5:0]  pat       [2];

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LAT(1), .INIT_FILE("")) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(rdy[0]), .req_we(we[0]),
        .req_funct3(f3[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
        .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .rsp_err(rerr[0])
    );

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LAT(2), .INIT_FILE("")) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(rdy[1]), .req_we(we[1]),
        .req_funct3(f3[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
        .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .rsp_err(rerr[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Apply the architectural rules to a request seen being accepted.
    task automatic model_accept(input int i);
        int          a, size;
        bit          legal, err;
        logic [31:0] v;
        a = int'(addr[i]);
        case (f3[i][1:0])
            2'b00:   size = 1;
            2'b01:   size = 2;
            default: size = 4;
        endcase
        legal = we[i] ? (f3[i] <= 3'd2) : (f3[i] <= 3'd2 || f3[i] == 3'd4 || f3[i] == 3'd5);
        err   = !legal || (addr[i] % size) != 0 || addr[i] >= 32'(DEPTH * 4);
        v     = 32'd0;
        if (!err && we[i]) begin
            for (int k = 0; k < size; k++) mm[i][a+k] = wdata[i][8*k +: 8];
        end else if (!err) begin
            for (int k = 0; k < size; k++) v[8*k +: 8] = mm[i][a+k];
            if (!f3[i][2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        end
        exp_rdata[i] = v;
        exp_err[i]   = err;
        pend[i]      = 1'b1;
        due[i]       = cyc + ((err || we[i]) ? 1 : lat_of(i));
        busy[i]      = due[i];
    endtask

    // Cycle-by-cycle compare of both controllers against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                pend[i] = 1'b0;
                busy[i] = cyc;
                check($sformatf("d%0d_rst_ready", i), 32'(rdy[i]), 32'd0);
                check($sformatf("d%0d_rst_rsp_valid", i), 32'(rv[i]), 32'd0);
            end else begin
                check($sformatf("d%0d_ready@%0d", i, cyc), 32'(rdy[i]), 32'(cyc > busy[i]));
                if (pend[i] && due[i] == cyc) begin
                    check($sformatf("d%0d_rsp_valid@%0d", i, cyc), 32'(rv[i]), 32'd1);
                    check($sformatf("d%0d_rsp_rdata@%0d", i, cyc), rdata[i], exp_rdata[i]);
                    check($sformatf("d%0d_rsp_err@%0d", i, cyc), 32'(rerr[i]), 32'(exp_err[i]));
                    pend[i] = 1'b0;
                end else begin
                    check($sformatf("d%0d_idle_rsp_valid@%0d", i, cyc), 32'(rv[i]), 32'd0);
                end
                if (valid[i] && rdy[i]) model_accept(i);
            end
        end
    end

    task automatic drive(input int i, input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        bit acc = 1'b0;
        bit got = 1'b0;
        @(posedge clk);
        #1;
        valid[i] = 1'b1; we[i] = w; f3[i] = f; addr[i] = a; wdata[i] = d;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = rdy[i];
        end
        @(posedge clk);
        #1 valid[i] = 1'b0;
        check($sformatf("d%0d_accepted_%h", i, a), 32'(acc), 32'd1);
        got_lat[i] = 0;
        for (int n = 1; n <= 10 && !got; n++) begin
            @(negedge clk);
            if (rv[i]) begin
                got          = 1'b1;
                got_lat[i]   = n;
                got_rdata[i] = rdata[i];
                got_err[i]   = rerr[i];
            end
        end
        check($sformatf("d%0d_responded_%h", i, a), 32'(got), 32'd1);
    endtask

    task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        fork
            drive(0, w, f, a, d);
            drive(1, w, f, a, d);
        join
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] r, input logic e);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_%s_rdata", i, name), got_rdata[i], r);
            check($sformatf("d%0d_%s_err", i, name), 32'(got_err[i]), 32'(e));
        end
    endtask

    task automatic burst(input int i);
        @(posedge clk);
        #1;
        valid[i] = 1'b1; we[i] = 1'b0; f3[i] = F_W; addr[i] = 32'h10; wdata[i] = 32'd0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            pat[i][5-n] = rdy[i];
        end
        @(posedge clk);
        #1 valid[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; we[i] = 1'b0; f3[i] = 3'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
            pend[i] = 1'b0; busy[i] = -1; due[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_reset_rdata", i), rdata[i], 32'd0);
            check($sformatf("d%0d_reset_err", i), 32'(rerr[i]), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Word store then load, latency, and hold after the response.
        do_req(1'b1, F_W, 32'h10, 32'hDEAD_BEEF); expect_rsp("sw10", 32'd0, 1'b0);
        do_req(1'b0, F_W, 32'h10, 32'd0);         expect_rsp("lw10", 32'hDEAD_BEEF, 1'b0);
        check("d0_load_latency", 32'(got_lat[0]), 32'd1);
        check("d1_load_latency", 32'(got_lat[1]), 32'd2);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("d%0d_rdata_hold", i), rdata[i], 32'hDEAD_BEEF);

        // Byte store and sub-word loads.
        do_req(1'b1, F_B,  32'h11, 32'h0000_00A5); expect_rsp("sb11", 32'd0, 1'b0);
        do_req(1'b0, F_W,  32'h10, 32'd0);         expect_rsp("lw10_b", 32'hDEAD_A5EF, 1'b0);
        do_req(1'b0, F_B,  32'h11, 32'd0);         expect_rsp("lb11", 32'hFFFF_FFA5, 1'b0);
        do_req(1'b0, F_BU, 32'h11, 32'd0);         expect_rsp("lbu11", 32'h0000_00A5, 1'b0);

        // Half store and half loads.
        do_req(1'b1, F_H,  32'h12, 32'h0000_8001); expect_rsp("sh12", 32'd0, 1'b0);
        do_req(1'b0, F_H,  32'h12, 32'd0);         expect_rsp("lh12", 32'hFFFF_8001, 1'b0);
        do_req(1'b0, F_HU, 32'h12, 32'd0);         expect_rsp("lhu12", 32'h0000_8001, 1'b0);
        do_req(1'b0, F_W,  32'h10, 32'd0);         expect_rsp("lw10_h", 32'h8001_A5EF, 1'b0);
        do_req(1'b0, F_B,  32'h10, 32'd0);         expect_rsp("lb10", 32'hFFFF_FFEF, 1'b0);
        do_req(1'b0, F_HU, 32'h10, 32'd0);         expect_rsp("lhu10", 32'h0000_A5EF, 1'b0);
        do_req(1'b0, F_B,  32'h13, 32'd0);         expect_rsp("lb13", 32'hFFFF_FF80, 1'b0);

        // Error cases: misaligned, out of range, illegal funct3; no RAM side effects.
        do_req(1'b1, F_W,  32'h00, 32'h0102_0304);       expect_rsp("sw00", 32'd0, 1'b0);
        do_req(1'b0, F_W,  32'h13, 32'd0);               expect_rsp("lw13_err", 32'd0, 1'b1);
        check("d0_err_latency", 32'(got_lat[0]), 32'd1);
        check("d1_err_latency", 32'(got_lat[1]), 32'd1);
        do_req(1'b1, F_H,  32'h11, 32'hFFFF_FFFF);       expect_rsp("sh11_err", 32'd0, 1'b1);
        do_req(1'b1, F_W,  32'h0001_0000, 32'hFFFF_FFFF); expect_rsp("sw_oor_err", 32'd0, 1'b1);
        do_req(1'b0, F_B,  32'h0001_0003, 32'd0);        expect_rsp("lb_oor_err", 32'd0, 1'b1);
        do_req(1'b0, 3'b011, 32'h10, 32'd0);             expect_rsp("ld_f3_err", 32'd0, 1'b1);
        do_req(1'b1, F_BU, 32'h00, 32'hFFFF_FFFF);       expect_rsp("st_f3_err", 32'd0, 1'b1);
        do_req(1'b0, F_W,  32'h10, 32'd0);               expect_rsp("lw10_after_err", 32'h8001_A5EF, 1'b0);
        do_req(1'b0, F_W,  32'h00, 32'd0);               expect_rsp("lw00_after_err", 32'h0102_0304, 1'b0);

        // Requests held valid back-to-back.
        fork
            burst(0);
            burst(1);
        join
        repeat (4) @(negedge clk);
        check("d0_burst_ready_pattern", 32'(pat[0]), 32'b101010);
        check("d1_burst_ready_pattern", 32'(pat[1]), 32'b100100);

        // Reset while a load is outstanding.
        do_req(1'b1, F_W, 32'h20, 32'h1234_5678); expect_rsp("sw20", 32'd0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b1; we[i] = 1'b0; f3[i] = F_W; addr[i] = 32'h20;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        valid[0] = 1'b0; valid[1] = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("d%0d_ready_after_release", i), 32'(rdy[i]), 32'd1);
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                check($sformatf("d%0d_no_rsp_after_reset", i), 32'(rv[i]), 32'd0);
        end
        do_req(1'b0, F_W, 32'h20, 32'd0); expect_rsp("lw20_after_reset", 32'h1234_5678, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
